stadd: RTL and testbench

Store-side lane-permute and write-enable generator for the 12-lane SMA datapath, the write-direction counterpart of the load path. It captures a 12-lane PE result vector on a store op and looks up a programmable store-table entry selected by `i_func`. It then routes each memory lane from any source lane and drives per-lane data-memory write strobes, registered, with a ready/stall handshake to the memory. The store table is programmed and read back over the shared external (ex) bus.

---
 rtl/stadd_pkg.sv | 41 ++++
 rtl/stadd_sttbl.sv | 82 ++++++++
 rtl/stadd.sv | 133 +++++++++++++
 tb/tb_stadd.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stadd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stadd_pkg
// Purpose  : Shared SMA constants and types for the store-side lane permute
//            (stadd) and its store-table register file (sttbl).
// Revision : 1.0 - initial release
// ============================================================================
package stadd_pkg;

    // Datapath geometry
    localparam int NUM_LANES  = 12;
    localparam int STSEL_W    = 4;                       // per-lane source select
    localparam int STMASK_LSB = NUM_LANES * STSEL_W;     // 48
    localparam int STTBL_W    = STMASK_LSB + NUM_LANES;  // 60

    // External (ex) bus decode
    localparam int REG_W_DEF  = 16;
    localparam int EXA_W_DEF  = 16;
    localparam int EXSEL_MSB  = 15;
    localparam int EXSEL_LSB  = 12;
    localparam logic [EXSEL_MSB-EXSEL_LSB:0] EX_STBL = 4'h3;

    // One store-table entry; mask sits above the select field so the packed
    // layout matches STMASK_LSB.
    typedef struct packed {
        logic [NUM_LANES-1:0]         mask;
        logic [STMASK_LSB-1:0]        sel;
    } sttbl_entry_t;

    // Identity routing: lane j sources lane j.
    function automatic logic [STMASK_LSB-1:0] identity_sel();
        logic [STMASK_LSB-1:0] s;
        s = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            s[j*STSEL_W +: STSEL_W] = STSEL_W'(j);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stadd_sttbl.sv
`default_nettype none
// ============================================================================
// Module   : sttbl
// Purpose  : Store-table register file. ENT entries of 12 x 4-bit lane
//            selects plus a 12-bit write mask, written (and optionally read
//            back) over the ex bus, looked up combinationally by index.
// Ports    : clk, rst_n (async, active-low)
//            we/re/addr/wd/rd - ex access, addr = {entry[3:0], word[1:0]}
//            idx              - lookup index
//            sel/mask         - looked-up entry fields
// Config   : STTBL_READBACK_EN - enables the registered ex read path;
//            otherwise rd is constant 0 and re is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module sttbl
    import stadd_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ENT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [5:0]            addr,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd,
    input  logic [3:0]            idx,
    output logic [STMASK_LSB-1:0] sel,
    output logic [NUM_LANES-1:0]  mask
);

    sttbl_entry_t tbl [ENT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < ENT; e++) begin
                tbl[e].sel  <= identity_sel();
                tbl[e].mask <= '0;
            end
        end else if (we) begin
            case (addr[1:0])
                2'd0:    tbl[addr[5:2]].sel[15:0]  <= wd[15:0];
                2'd1:    tbl[addr[5:2]].sel[31:16] <= wd[15:0];
                2'd2:    tbl[addr[5:2]].sel[47:32] <= wd[15:0];
                default: tbl[addr[5:2]].mask       <= wd[11:0];
            endcase
        end
    end

    assign sel  = tbl[idx].sel;
    assign mask = tbl[idx].mask;

`ifdef STTBL_READBACK_EN
    logic [15:0] rd_word;

    always_comb begin
        rd_word = '0;
        case (addr[1:0])
            2'd0:    rd_word = tbl[addr[5:2]].sel[15:0];
            2'd1:    rd_word = tbl[addr[5:2]].sel[31:16];
            2'd2:    rd_word = tbl[addr[5:2]].sel[47:32];
            default: rd_word = {4'b0, tbl[addr[5:2]].mask};
        endcase
    end

    // Read data is held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= '0;
        end else if (re) begin
            rd <= DATA_W'(rd_word);
        end
    end
`else
    logic unused_re;
    assign unused_re = re;
    assign rd        = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/stadd.sv
`default_nettype none
// ============================================================================
// Module   : stadd
// Purpose  : Store-side lane permute and write-enable generator. Captures a
//            12-lane PE result on a store op, routes each memory lane from a
//            table-selected source lane and drives registered per-lane write
//            strobes with a ready/stall handshake to data memory.
// Ports    : clk, rst_n (async, active-low)
//            i_st_op/i_func/i_pedata - store op, table index, PE lanes
//            o_dmemout/o_dmem_we     - permuted data, per-lane write enables
//            i_dmem_ready/o_ready    - memory accept / op accept handshake
//            i_exwe/i_exre/i_exa/i_exwd/o_exrd - store-table ex access
// Config   : STTBL_READBACK_EN - enables store-table readback on o_exrd.
// Revision : 1.0 - initial release
// ============================================================================
module stadd
    import stadd_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 12,
    parameter int ENT    = 16,
    parameter int REG_W  = REG_W_DEF,
    parameter int EXA_W  = EXA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_st_op,
    input  logic [REG_W-1:0]        i_func,
    input  logic [DATA_W*LANES-1:0] i_pedata,
    output logic [DATA_W*LANES-1:0] o_dmemout,
    output logic [LANES-1:0]        o_dmem_we,
    input  logic                    i_dmem_ready,
    output logic                    o_ready,
    input  logic                    i_exwe,
    input  logic                    i_exre,
    input  logic [EXA_W-1:0]        i_exa,
    input  logic [DATA_W-1:0]       i_exwd,
    output logic [DATA_W-1:0]       o_exrd
);

    logic                    ex_hit;
    logic [STMASK_LSB-1:0]   tbl_sel;
    logic [NUM_LANES-1:0]    tbl_mask;

    logic                    s1_v;
    logic [DATA_W*LANES-1:0] s1_data;
    logic [STMASK_LSB-1:0]   s1_sel;
    logic [NUM_LANES-1:0]    s1_mask;

    logic                    stall;
    logic                    accept;
    logic [DATA_W-1:0]       src [16];
    logic [DATA_W*LANES-1:0] perm_data;
    logic [LANES-1:0]        perm_we;

    logic unused_bits;
    assign unused_bits = ^{i_func, i_exa};

    assign ex_hit = (i_exa[EXSEL_MSB:EXSEL_LSB] == EX_STBL);

    sttbl #(
        .DATA_W (DATA_W),
        .ENT    (ENT)
    ) u_sttbl (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (i_exwe & ex_hit),
        .re    (i_exre & ex_hit),
        .addr  (i_exa[5:0]),
        .wd    (i_exwd),
        .rd    (o_exrd),
        .idx   (i_func[3:0]),
        .sel   (tbl_sel),
        .mask  (tbl_mask)
    );

    assign stall   = (|o_dmem_we) & ~i_dmem_ready;
    assign o_ready = ~(s1_v & stall);
    assign accept  = i_st_op & o_ready;

    // Stage 1. The table entry is bound when the op is accepted, so it sees
    // the table as it stood before that edge; an ex write landing on the
    // same edge (or while the op waits) only affects later ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_sel  <= '0;
            s1_mask <= '0;
        end else if (o_ready) begin
            s1_v <= accept;
            if (accept) begin
                s1_data <= i_pedata;
                s1_sel  <= tbl_sel;
                s1_mask <= tbl_mask;
            end
        end
    end

    // Crossbar. Source slots 12..15 read as zero so an out-of-range select
    // yields zero data without a separate guard on the data path.
    always_comb begin
        src       = '{default: '0};
        perm_data = '0;
        perm_we   = '0;
        for (int k = 0; k < LANES; k++) begin
            src[k] = s1_data[k*DATA_W +: DATA_W];
        end
        for (int j = 0; j < LANES; j++) begin
            perm_data[j*DATA_W +: DATA_W] = src[s1_sel[j*STSEL_W +: STSEL_W]];
            perm_we[j] = s1_mask[j] &
                         (s1_sel[j*STSEL_W +: STSEL_W] < STSEL_W'(LANES));
        end
    end

    // Stage 2: holds under stall; write enables drop when nothing new arrives
    // while data keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_dmemout <= '0;
            o_dmem_we <= '0;
        end else if (!stall) begin
            if (s1_v) begin
                o_dmemout <= perm_data;
                o_dmem_we <= perm_we;
            end else begin
                o_dmem_we <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stadd.sv
`default_nettype none
// ============================================================================
// Module   : tb_stadd
// Purpose  : Directed self-checking bench for stadd: reset state, table
//            programming, permute/mask behaviour, stall hold, same-edge
//            table update, readback (STTBL_READBACK_EN) and mid-op reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stadd;
    import stadd_pkg::*;

    localparam int DW = 16;
    localparam int L  = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_st_op;
    logic [15:0]     i_func;
    logic [DW*L-1:0] i_pedata;
    logic [DW*L-1:0] o_dmemout;
    logic [L-1:0]    o_dmem_we;
    logic            i_dmem_ready;
    logic            o_ready;
    logic            i_exwe;
    logic            i_exre;
    logic [15:0]     i_exa;
    logic [DW-1:0]   i_exwd;
    logic [DW-1:0]   o_exrd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stadd dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_st_op      (i_st_op),
        .i_func       (i_func),
        .i_pedata     (i_pedata),
        .o_dmemout    (o_dmemout),
        .o_dmem_we    (o_dmem_we),
        .i_dmem_ready (i_dmem_ready),
        .o_ready      (o_ready),
        .i_exwe       (i_exwe),
        .i_exre       (i_exre),
        .i_exa        (i_exa),
        .i_exwd       (i_exwd),
        .o_exrd       (o_exrd)
    );

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [191:0] ramp(input logic [15:0] base);
        logic [191:0] v;
        for (int k = 0; k < L; k++) v[k*DW +: DW] = base + 16'(k);
        return v;
    endfunction

    // Lane j carries base + 11 - j (reverse routing of a ramp).
    function automatic logic [191:0] rev(input logic [15:0] base);
        logic [191:0] v;
        for (int j = 0; j < L; j++) v[j*DW +: DW] = base + 16'(11 - j);
        return v;
    endfunction

    function automatic logic [15:0] exaddr(input logic [3:0] ent, input logic [1:0] word);
        return {EX_STBL, 6'b0, ent, word};
    endfunction

    task automatic ex_wr(input logic [3:0] ent, input logic [1:0] word, input logic [15:0] d);
        i_exa  = exaddr(ent, word);
        i_exwd = d;
        i_exwe = 1'b1;
        tick();
        i_exwe = 1'b0;
    endtask

    task automatic op(input logic [3:0] f, input logic [191:0] d);
        i_st_op  = 1'b1;
        i_func   = {12'h0, f};
        i_pedata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [191:0] e;
        rst_n        = 1'b0;
        i_st_op      = 1'b0;
        i_func       = '0;
        i_pedata     = '0;
        i_dmem_ready = 1'b1;
        i_exwe       = 1'b0;
        i_exre       = 1'b0;
        i_exa        = '0;
        i_exwd       = '0;

        // Reset state
        #12;
        check("rst_dmemout", o_dmemout, 0);
        check("rst_we",      o_dmem_we, 0);
        check("rst_exrd",    o_exrd,    0);
        check("rst_ready",   o_ready,   1);
        rst_n = 1'b1;
        tick();

        // Entry 0 after reset: identity routing, mask 0
        op(4'd0, ramp(16'h00A0));
        tick();
        i_st_op = 1'b0;
        tick();
        check("e0_we",    o_dmem_we, 0);
        check("e0_data",  o_dmemout, ramp(16'h00A0));
        check("e0_ready", o_ready,   1);

        // Entry 3: reverse routing, full mask
        ex_wr(4'd3, 2'd0, 16'h89AB);
        ex_wr(4'd3, 2'd1, 16'h4567);
        ex_wr(4'd3, 2'd2, 16'h0123);
        ex_wr(4'd3, 2'd3, 16'h0FFF);
        op(4'd3, ramp(16'h0100));
        tick();
        i_st_op = 1'b0;
        check("e3_we_lat", o_dmem_we, 0);
        tick();
        check("e3_we",   o_dmem_we, 12'hFFF);
        check("e3_data", o_dmemout, rev(16'h0100));
        tick();
        check("e3_we_drop",  o_dmem_we, 0);
        check("e3_data_hold", o_dmemout, rev(16'h0100));

        // Entry 5: mask 0x00F, lane 2 selects out-of-range lane 13
        ex_wr(4'd5, 2'd0, 16'h3D10);
        ex_wr(4'd5, 2'd1, 16'h7654);
        ex_wr(4'd5, 2'd2, 16'hBA98);
        ex_wr(4'd5, 2'd3, 16'h000F);
        op(4'd5, ramp(16'h0200));
        tick();
        i_st_op = 1'b0;
        tick();
        e = ramp(16'h0200);
        e[47:32] = 16'h0000;
        check("e5_we",   o_dmem_we, 12'h00B);
        check("e5_data", o_dmemout, e);
        tick();

        // Back-to-back ops against a stalled memory
        i_dmem_ready = 1'b0;
        op(4'd3, ramp(16'h0300));
        tick();
        op(4'd3, ramp(16'h0400));
        tick();
        check("stall_ready0", o_ready,   0);
        check("stall_we",     o_dmem_we, 12'hFFF);
        check("stall_dataA",  o_dmemout, rev(16'h0300));
        op(4'd3, ramp(16'h0700));   // must be ignored
        tick();
        check("stall_hold1", o_dmemout, rev(16'h0300));
        check("stall_ready1", o_ready,  0);
        i_st_op = 1'b0;
        tick();
        check("stall_hold2", o_dmem_we, 12'hFFF);
        check("stall_hold2d", o_dmemout, rev(16'h0300));
        i_dmem_ready = 1'b1;
        tick();
        check("stall_dataB",  o_dmemout, rev(16'h0400));
        check("stall_weB",    o_dmem_we, 12'hFFF);
        check("stall_readyB", o_ready,   1);
        tick();
        check("stall_done_we",   o_dmem_we, 0);
        check("stall_done_data", o_dmemout, rev(16'h0400));

        // Ex write to entry 3 mask on the same edge as an op using entry 3
        i_exa  = exaddr(4'd3, 2'd3);
        i_exwd = 16'h0001;
        i_exwe = 1'b1;
        op(4'd3, ramp(16'h0500));
        tick();
        i_exwe = 1'b0;
        op(4'd3, ramp(16'h0600));
        tick();
        check("same_edge_we",   o_dmem_we, 12'hFFF);
        check("same_edge_data", o_dmemout, rev(16'h0500));
        i_st_op = 1'b0;
        tick();
        check("next_op_we",   o_dmem_we, 12'h001);
        check("next_op_data", o_dmemout, rev(16'h0600));
        tick();

        // Readback
        ex_wr(4'd3, 2'd3, 16'hABCD);
        i_exa  = exaddr(4'd3, 2'd3);
        i_exre = 1'b1;
        tick();
        i_exre = 1'b0;
        i_exa  = exaddr(4'd3, 2'd0);
`ifdef STTBL_READBACK_EN
        check("rb_mask", o_exrd, 16'h0BCD);
        tick();
        check("rb_hold", o_exrd, 16'h0BCD);
        i_exre = 1'b1;
        tick();
        i_exre = 1'b0;
        check("rb_sel0", o_exrd, 16'h89AB);
`else
        check("rb_off", o_exrd, 0);
        i_exre = 1'b1;
        tick();
        i_exre = 1'b0;
        check("rb_off2", o_exrd, 0);
`endif

        // Reset while an op sits in stage 1
        op(4'd3, ramp(16'h0800));
        tick();
        i_st_op = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",    o_dmem_we, 0);
        check("mid_rst_data",  o_dmemout, 0);
        check("mid_rst_ready", o_ready,   1);
        check("mid_rst_exrd",  o_exrd,    0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_we",   o_dmem_we, 0);
        check("post_rst_data", o_dmemout, 0);

        // Table back to identity / mask 0 after reset
        op(4'd3, ramp(16'h0900));
        tick();
        i_st_op = 1'b0;
        tick();
        check("post_rst_id_data", o_dmemout, ramp(16'h0900));
        check("post_rst_id_we",   o_dmem_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
